// File: rtl/proc_controller_p.sv
// Multi-cycle instruction controller: req/ack instruction fetch, 4-bit opcode decode, Moore controls.
// Optional PROC_BRANCH_EN adds JMP (opcode 6) and JZ (opcode 7); otherwise both decode as NOOP.
module proc_controller_p #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned D_AW = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  output logic [PC_W-1:0] IM_addr,
  output logic            IM_req,
  input  logic            IM_ack,
  input  logic [15:0]     IM_data,
  input  logic            ALU_Zero,
  output logic [2:0]      ALU_s,
  output logic [D_AW-1:0] D_addr,
  output logic            D_wr,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic            RF_W_sel,
  output logic [15:0]     IR_Out,
  output logic [PC_W-1:0] PC_Out,
  output logic [3:0]      State_Out,
  output logic            Halted
);

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoadA  = 4'd3,
    StLoadB  = 4'd4,
    StStore  = 4'd5,
    StAlu    = 4'd6,
`ifdef PROC_BRANCH_EN
    StJmp    = 4'd7,
    StJz     = 4'd8,
`endif
    StHalt   = 4'd9
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0]      op, fa, fb, fc;
  logic [D_AW-1:0] store_addr, load_addr;

  assign op         = ir_q[15:12];
  assign fa         = ir_q[11:8];
  assign fb         = ir_q[7:4];
  assign fc         = ir_q[3:0];
  assign store_addr = ir_q[D_AW-1:0];
  assign load_addr  = ir_q[D_AW+3:4];

`ifdef PROC_BRANCH_EN
  logic [PC_W-1:0] jmp_target, jz_target;
  logic [15:0]     jz_wide;

  // JZ target is the low byte, zero-extended or truncated to the PC width.
  assign jz_wide    = {8'h00, ir_q[7:0]};
  assign jz_target  = jz_wide[PC_W-1:0];
  assign jmp_target = ir_q[PC_W-1:0];
`else
  logic unused_alu_zero;
  assign unused_alu_zero = ALU_Zero;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StInit;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StInit:   state_d = StFetch;
      StFetch: begin
        if (IM_ack) begin
          ir_d    = IM_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (op)
          4'd1:       state_d = StStore;
          4'd2:       state_d = StLoadA;
          4'd3, 4'd4: state_d = StAlu;
          4'd5:       state_d = StHalt;
`ifdef PROC_BRANCH_EN
          4'd6:       state_d = StJmp;
          4'd7:       state_d = StJz;
`endif
          default:    state_d = StFetch;
        endcase
      end
      StLoadA:  state_d = StLoadB;
      StLoadB:  state_d = StFetch;
      StStore:  state_d = StFetch;
      StAlu:    state_d = StFetch;
`ifdef PROC_BRANCH_EN
      StJmp: begin
        pc_d    = jmp_target;
        state_d = StFetch;
      end
      StJz: begin
        if (ALU_Zero) pc_d = jz_target;
        state_d = StFetch;
      end
`endif
      StHalt:   state_d = StHalt;
      default:  state_d = StInit;
    endcase
  end

  // Controls depend only on state and IR; ALU_Zero feeds next-state only.
  always_comb begin
    IM_req     = 1'b0;
    ALU_s      = 3'd0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_W_sel   = 1'b0;
    case (state_q)
      StFetch:  IM_req = 1'b1;
      StLoadA:  D_addr = load_addr;
      StLoadB: begin
        D_addr    = load_addr;
        RF_W_addr = fc;
        RF_W_sel  = 1'b1;
        RF_W_en   = 1'b1;
      end
      StStore: begin
        RF_Ra_addr = fa;
        D_addr     = store_addr;
        D_wr       = 1'b1;
      end
      StAlu: begin
        RF_Ra_addr = fa;
        RF_Rb_addr = fb;
        ALU_s      = (op == 4'd4) ? 3'd2 : 3'd1;
        RF_W_addr  = fc;
        RF_W_en    = 1'b1;
      end
`ifdef PROC_BRANCH_EN
      StJz:     RF_Ra_addr = fa;
`endif
      default: ;
    endcase
  end

  assign IM_addr   = pc_q;
  assign PC_Out    = pc_q;
  assign IR_Out    = ir_q;
  assign State_Out = state_q;
  assign Halted    = (state_q == StHalt);

endmodule

// File: doc/proc_controller_p.md
# proc_controller_p

Parametrised multi-cycle instruction controller for the 16-bit processor; successor to the fixed 5-bit-PC controller. Fetches instructions from an external instruction memory over a req/ack handshake, decodes a 4-bit opcode, and drives the register file, data memory and ALU controls of the datapath. Adds a parametrised PC width, wait-state tolerant fetch, HALT, and optional jump/branch-if-zero.

## Interface
- PC_W, 8: program counter width (4..12)
- D_AW, 8: data-memory address width (1..8)
- Clk  in  1  processor clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- IM_addr  out  PC_W  instruction address (= PC)
- IM_req  out  1  fetch request
- IM_ack  in  1  instruction valid on IM_data this cycle
- IM_data  in  16  instruction word
- ALU_Zero  in  1  datapath ALU output == 0 (combinational)
- ALU_s  out  3  ALU select: 0 pass A, 1 A+B, 2 A−B
- D_addr  out  D_AW  data-memory address
- D_wr  out  1  data-memory write enable
- RF_Ra_addr, RF_Rb_addr  out  4  register-file read addresses
- RF_W_addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_W_sel  out  1  write source: 0 ALU, 1 data memory
- IR_Out  out  16  instruction register
- PC_Out  out  PC_W  program counter
- State_Out  out  4  current state code
- Halted  out  1  high while in HALT

## Operation
- Fields: op=IR[15:12], fA=IR[11:8], fB=IR[7:4], fC=IR[3:0].
- Opcodes: 0 NOOP; 1 STORE D[IR[D_AW-1:0]] <= RF[fA]; 2 LOAD RF[fC] <= D[IR[D_AW+3:4]]; 3 ADD RF[fC] <= RF[fA]+RF[fB]; 4 SUB RF[fC] <= RF[fA]−RF[fB]; 5 HALT; 6 JMP PC <= IR[PC_W-1:0]; 7 JZ if RF[fA]==0 then PC <= IR[7:0] zero-extended/truncated to PC_W; 8–15 illegal, executed as NOOP.
- States (State_Out): INIT 0, FETCH 1, DECODE 2, LOAD_A 3, LOAD_B 4, STORE 5, ALU 6, JMP 7, JZ 8, HALT 9.
- INIT → FETCH unconditionally.
- FETCH: IM_req=1; hold until IM_ack=1; on that edge IR <= IM_data, PC <= PC+1 (mod 2^PC_W), → DECODE.
- DECODE: → FETCH (NOOP/illegal), STORE, LOAD_A, ALU (ADD/SUB), HALT, JMP, JZ.
- LOAD_A: D_addr driven → LOAD_B. LOAD_B: D_addr held, RF_W_addr=fC, RF_W_sel=1, RF_W_en=1 → FETCH.
- STORE: RF_Ra_addr=fA, D_addr driven, D_wr=1 → FETCH.
- ALU: RF_Ra_addr=fA, RF_Rb_addr=fB, ALU_s=1/2, RF_W_addr=fC, RF_W_sel=0, RF_W_en=1 → FETCH.
- JMP: PC loaded → FETCH. JZ: RF_Ra_addr=fA, ALU_s=0; PC loaded iff ALU_Zero → FETCH.
- HALT: absorbing; Halted=1; only Reset exits.
- All control outputs are decoded from state and IR only (Moore); inactive value 0.

## Timing
- Reset asserted (low): state INIT, PC=0, IR=0, all outputs 0 (IM_addr=0, State_Out=0, Halted=0), immediately and independent of Clk.
- First IM_req one cycle after Reset deasserts.
- Cycles per instruction, with zero-wait fetch (IM_ack in first FETCH cycle): NOOP 2, STORE/ALU/JMP/JZ 3, LOAD 4; each IM_ack wait cycle adds 1.
- IM_ack ignored outside FETCH. IM_data sampled only on the IM_ack edge.
- PC wraps 2^PC_W−1 → 0 on fetch increment.
- JMP/JZ target overrides the already-incremented PC.
- Reset mid-instruction (any state, including stalled FETCH or LOAD_B) aborts with no write enable asserted after reset asserts.

## Configuration
- PROC_BRANCH_EN defined: opcodes 6 (JMP) and 7 (JZ) implemented as above; states 7, 8 exist.
- Not defined: opcodes 6 and 7 treated as illegal (NOOP, DECODE → FETCH); JMP/JZ states absent; ALU_Zero unused.

## Test plan
- Reset low mid-FETCH with IM_ack stalled → PC=0, IR=0, State_Out=0, all enables 0; after release IM_req=1 next cycle with IM_addr=0.
- Program ADD 0x3123 (RF1+RF2→RF3), IM_ack immediate → RF_W_en=1 with RF_W_addr=3, ALU_s=1, RF_W_sel=0 exactly in cycle 3; PC=1.
- LOAD 0x2A55 with IM_ack after 2 wait cycles → D_addr=0xA5, RF_W_en=1, RF_W_sel=1, RF_W_addr=5 in LOAD_B; total 6 cycles.
- PC_W=4, PC=15, NOOP fetched → PC wraps to 0.
- PROC_BRANCH_EN: JZ 0x7410 with ALU_Zero=1 → PC=0x10; with ALU_Zero=0 → PC=previous+1. Without macro → NOOP, PC+1.
- HALT 0x5000 → State_Out=9, Halted=1, IM_req stays 0 for 20 cycles; Reset low → INIT.
